// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, lock state encoding and counter helpers.
// vga_counter uses the same package, so the capture side always agrees with the display side.
package vga_timing_pkg;

   localparam int H_VISIBLE = 640;
   localparam int H_SYNC    = 96;
   localparam int H_BACK    = 48;
   localparam int H_TOTAL   = 800;
   localparam int V_VISIBLE = 480;
   localparam int V_SYNC    = 2;
   localparam int V_BACK    = 33;
   localparam int V_TOTAL   = 525;

   localparam int XOFF = H_SYNC + H_BACK;
   localparam int YOFF = V_SYNC + V_BACK;

   localparam int CNT_W = 10;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } lock_state_e;

   // Increment that sticks at the top value, so a missing sync can never wrap into a false match.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
      return (value == CNT_MAX) ? value : value + CNT_W'(1);
   endfunction

endpackage

// File: rtl/vga_capture_if.sv
// Pixel-write stream produced by vga_capture for a frame buffer or checker.
interface vga_capture_if;
   import vga_timing_pkg::*;

   logic             pix_valid;
   logic [CNT_W-1:0] pix_x;
   logic [CNT_W-1:0] pix_y;
   logic [7:0]       pix_color;

   modport master (output pix_valid, pix_x, pix_y, pix_color);
   modport slave  (input  pix_valid, pix_x, pix_y, pix_color);

endinterface

// File: rtl/vga_sync_edge.sv
// Stage-1 register for one sync line: normalises polarity (1 = asserted) and flags the assertion edge.
module vga_sync_edge #(
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic rise
);
   import vga_timing_pkg::*;

   logic level;
   logic level_prev;

   // Register the pin and keep one cycle of history; both reset to "deasserted".
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses <= so every register samples pre-edge values, independent of statement order.
      if (!reset) begin
         level      <= 1'b0;
         level_prev <= 1'b0;
      end else begin
         level      <= raw ^ ACTIVE_LOW;
         level_prev <= level;
      end
   end

   assign rise = level & ~level_prev;

endmodule

// File: rtl/vga_capture.sv
// VGA receiver: recovers pixel position from sync edges, checks timing, locks, and emits pixel writes.
module vga_capture #(
   parameter int H_VISIBLE       = vga_timing_pkg::H_VISIBLE,
   parameter int H_SYNC          = vga_timing_pkg::H_SYNC,
   parameter int H_BACK          = vga_timing_pkg::H_BACK,
   parameter int H_TOTAL         = vga_timing_pkg::H_TOTAL,
   parameter int V_VISIBLE       = vga_timing_pkg::V_VISIBLE,
   parameter int V_SYNC          = vga_timing_pkg::V_SYNC,
   parameter int V_BACK          = vga_timing_pkg::V_BACK,
   parameter int V_TOTAL         = vga_timing_pkg::V_TOTAL,
   parameter bit SYNC_ACTIVE_LOW = 1'b1,
   parameter int LOCK_FRAMES     = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          enable,
   input  logic [7:0]    color,
   input  logic          HSync,
   input  logic          VSync,
   vga_capture_if.master pix,
   output logic          locked,
   output logic          frame_start,
   output logic          sync_error
);
   import vga_timing_pkg::CNT_W;
   import vga_timing_pkg::lock_state_e;
   import vga_timing_pkg::SEARCH;
   import vga_timing_pkg::VERIFY;
   import vga_timing_pkg::LOCKED;
   import vga_timing_pkg::sat_inc;

   localparam logic [CNT_W-1:0] X_LO   = CNT_W'(H_SYNC + H_BACK);
   localparam logic [CNT_W-1:0] X_HI   = CNT_W'(H_SYNC + H_BACK + H_VISIBLE);
   localparam logic [CNT_W-1:0] Y_LO   = CNT_W'(V_SYNC + V_BACK);
   localparam logic [CNT_W-1:0] Y_HI   = CNT_W'(V_SYNC + V_BACK + V_VISIBLE);
   localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
   localparam logic [3:0]       GOOD_LAST = 4'(LOCK_FRAMES - 1);

   logic [7:0]       color_q;
   logic             h_edge;
   logic             v_edge;
   logic [CNT_W-1:0] h_cnt;
   logic [CNT_W-1:0] v_cnt;
   logic [CNT_W-1:0] h_next;
   logic [CNT_W-1:0] v_next;
   logic             line_err;
   logic             frame_err;
   logic             err;
   logic             visible;
   logic             capture;
   lock_state_e      state;
   logic [3:0]       good_frames;

   vga_sync_edge #(.ACTIVE_LOW(SYNC_ACTIVE_LOW)) u_hsync (
      .clk   (clk),
      .reset (reset),
      .raw   (HSync),
      .rise  (h_edge)
   );

   vga_sync_edge #(.ACTIVE_LOW(SYNC_ACTIVE_LOW)) u_vsync (
      .clk   (clk),
      .reset (reset),
      .raw   (VSync),
      .rise  (v_edge)
   );

   // Stage-1 color register, aligned with the sync samples held inside vga_sync_edge.
   always_ff @(posedge clk) begin
      if (!reset) color_q <= '0;
      else        color_q <= color;
   end

   // Position of the stage-1 sample; a VSync edge overrides the line advance of a coincident HSync edge.
   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can infer a latch.
      h_next = sat_inc(h_cnt);
      v_next = v_cnt;
      if (h_edge) begin
         h_next = '0;
         v_next = sat_inc(v_cnt);
      end
      if (v_edge) v_next = '0;
   end

   // A line/frame must end exactly at its nominal length: early edge or overrun are both violations.
   assign line_err  = h_edge ? (h_cnt != H_LAST) : (h_cnt == H_LAST);
   assign frame_err = v_edge ? (v_cnt != V_LAST) : (h_edge && (v_cnt == V_LAST));
   assign err       = line_err | frame_err;

   assign visible = (h_next >= X_LO) && (h_next < X_HI) && (v_next >= Y_LO) && (v_next < Y_HI);
   // An error while locked drops lock at this edge, so it must already suppress this pixel.
   assign capture = locked & ~err & enable & visible;

   // Position counters and the pixel write port, registered together so pix_* describe the same sample.
   always_ff @(posedge clk) begin
      if (!reset) begin
         h_cnt         <= '0;
         v_cnt         <= '0;
         pix.pix_valid <= 1'b0;
         pix.pix_x     <= '0;
         pix.pix_y     <= '0;
         pix.pix_color <= '0;
      end else begin
         h_cnt         <= h_next;
         v_cnt         <= v_next;
         pix.pix_valid <= capture;
         if (capture) begin
            pix.pix_x     <= h_next - X_LO;
            pix.pix_y     <= v_next - Y_LO;
            pix.pix_color <= color_q;
         end
      end
   end

   // Lock state machine with registered locked / sync_error / frame_start.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= SEARCH;
         good_frames <= '0;
         locked      <= 1'b0;
         sync_error  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         frame_start <= v_edge;
         sync_error  <= 1'b0;
         case (state)
            SEARCH: begin
               if (v_edge) begin
                  state       <= VERIFY;
                  good_frames <= '0;
               end
            end
            VERIFY: begin
               if (err) begin
                  state      <= SEARCH;
                  sync_error <= 1'b1;
               end else if (v_edge) begin
                  good_frames <= good_frames + 4'd1;
                  if (good_frames == GOOD_LAST) begin
                     state  <= LOCKED;
                     locked <= 1'b1;
                  end
               end
            end
            LOCKED: begin
               if (err) begin
                  state      <= SEARCH;
                  locked     <= 1'b0;
                  sync_error <= 1'b1;
               end
            end
            default: begin
               state  <= SEARCH;
               locked <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture using a scaled-down timing (16x10 total, 8x4 visible) to keep frames short.
module tb_vga_capture;

   localparam int T_HV = 8;
   localparam int T_HS = 2;
   localparam int T_HB = 2;
   localparam int T_HT = 16;
   localparam int T_VV = 4;
   localparam int T_VS = 1;
   localparam int T_VB = 2;
   localparam int T_VT = 10;
   localparam int XO = T_HS + T_HB;
   localparam int YO = T_VS + T_VB;
   localparam int FRAME = T_HT * T_VT;
   localparam int FRAME_PIX = T_HV * T_VV;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic [7:0] color;
   logic       HSync;
   logic       VSync;
   logic       locked;
   logic       frame_start;
   logic       sync_error;

   vga_capture_if pix_bus ();

   vga_capture #(
      .H_VISIBLE(T_HV), .H_SYNC(T_HS), .H_BACK(T_HB), .H_TOTAL(T_HT),
      .V_VISIBLE(T_VV), .V_SYNC(T_VS), .V_BACK(T_VB), .V_TOTAL(T_VT),
      .SYNC_ACTIVE_LOW(1'b1), .LOCK_FRAMES(2)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .color       (color),
      .HSync       (HSync),
      .VSync       (VSync),
      .pix         (pix_bus),
      .locked      (locked),
      .frame_start (frame_start),
      .sync_error  (sync_error)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // ---------------- stimulus generator ----------------
   int gx = 0, gy = 0;
   int line_len = T_HT;
   bit hold_h = 1'b0;
   int hstart_cyc = 0;
   int first_cyc = 0;

   task automatic gen_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         HSync = hold_h ? 1'b1 : !(gx < T_HS);
         VSync = !(gy < T_VS);
         if (gx >= XO && gx < XO + T_HV && gy >= YO && gy < YO + T_VV)
            color = 8'((gx - XO) ^ (gy - YO));
         else
            color = 8'hFF;
         if (gx == 0) hstart_cyc = cyc;
         if (gx == XO && gy == YO) first_cyc = cyc;
         if (gx >= line_len - 1) begin
            gx = 0;
            gy = (gy == T_VT - 1) ? 0 : gy + 1;
         end else begin
            gx++;
         end
      end
   endtask

   task automatic gen_to_frame_start();
      int guard = 0;
      while (!(gx == 0 && gy == 0) && guard < 2 * FRAME) begin
         gen_cycles(1);
         guard++;
      end
      check("frame_align", int'(gx == 0 && gy == 0), 1);
   endtask

   // ---------------- output monitor ----------------
   int fs_count = 0, lock_fs = 0, err_total = 0, err_cyc = 0, err_fs = 0;
   int pix_total = 0, px_cnt = 0, done_cnt = 0;
   int fx = 0, fy = 0, lx = 0, ly = 0, done_fx = 0, done_fy = 0, done_lx = 0, done_ly = 0;
   bit locked_prev = 1'b0, err_prev = 1'b0, locked_after_err = 1'b1;

   always @(negedge clk) begin
      if (frame_start) begin
         fs_count++;
         done_cnt = px_cnt;
         done_fx = fx; done_fy = fy; done_lx = lx; done_ly = ly;
         px_cnt = 0;
      end
      if (locked && !locked_prev) lock_fs = fs_count;
      locked_prev = locked;
      if (err_prev) locked_after_err = locked;
      err_prev = sync_error;
      if (sync_error) begin
         err_total++;
         err_cyc = cyc;
         err_fs = fs_count;
      end
      if (pix_bus.pix_valid) begin
         if (px_cnt == 0) begin
            fx = int'(pix_bus.pix_x);
            fy = int'(pix_bus.pix_y);
         end
         lx = int'(pix_bus.pix_x);
         ly = int'(pix_bus.pix_y);
         px_cnt++;
         pix_total++;
         check("pix_color", int'(pix_bus.pix_color), int'(pix_bus.pix_x[7:0] ^ pix_bus.pix_y[7:0]));
         check("pix_range", int'(pix_bus.pix_x < T_HV && pix_bus.pix_y < T_VV), 1);
         if (pix_bus.pix_x == 0 && pix_bus.pix_y == 0) check("latency", cyc - first_cyc, 2);
      end
   end

   task automatic check_all_zero(input string phase);
      check({phase, "_pix_valid"},   int'(pix_bus.pix_valid), 0);
      check({phase, "_pix_x"},       int'(pix_bus.pix_x), 0);
      check({phase, "_pix_y"},       int'(pix_bus.pix_y), 0);
      check({phase, "_pix_color"},   int'(pix_bus.pix_color), 0);
      check({phase, "_locked"},      int'(locked), 0);
      check({phase, "_frame_start"}, int'(frame_start), 0);
      check({phase, "_sync_error"},  int'(sync_error), 0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int fs0, px0, e0, px1, fsr;
      reset = 1'b0; enable = 1'b1; HSync = 1'b1; VSync = 1'b1; color = 8'h00;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      reset = 1'b1;

      // Lock: first VSync edge enters VERIFY, two good frames follow.
      gen_cycles(3 * FRAME);
      check("lock_rise", int'(locked), 1);
      check("lock_edge", lock_fs, 3);

      // Full locked frame: count, first and last coordinates, then held outputs.
      gen_cycles(FRAME);
      check("frame_pix",   done_cnt, FRAME_PIX);
      check("first_x",     done_fx, 0);
      check("first_y",     done_fy, 0);
      check("last_x",      done_lx, T_HV - 1);
      check("last_y",      done_ly, T_VV - 1);
      check("hold_valid",  int'(pix_bus.pix_valid), 0);
      check("hold_x",      int'(pix_bus.pix_x), T_HV - 1);
      check("hold_y",      int'(pix_bus.pix_y), T_VV - 1);
      check("hold_color",  int'(pix_bus.pix_color), (T_HV - 1) ^ (T_VV - 1));

      // enable=0 for one frame: no pixels, lock kept, one frame_start.
      fs0 = fs_count; px0 = pix_total; e0 = err_total;
      enable = 1'b0;
      gen_cycles(FRAME);
      enable = 1'b1;
      check("en_no_pix",  pix_total - px0, 0);
      check("en_locked",  int'(locked), 1);
      check("en_fs",      fs_count - fs0, 1);
      check("en_no_err",  err_total - e0, 0);

      // Shorten line 4 by one clock while locked.
      gen_cycles(4 * T_HT);
      e0 = err_total;
      line_len = T_HT - 1;
      gen_cycles(T_HT - 1);
      line_len = T_HT;
      gen_cycles(5);
      check("short_err",    err_total - e0, 1);
      check("short_err_at", err_cyc - hstart_cyc, 2);
      check("short_unlock", int'(locked_after_err), 0);
      px1 = pix_total;
      gen_to_frame_start();
      check("short_no_pix",   pix_total - px1, 0);
      check("short_err_once", err_total - e0, 1);
      gen_cycles(3 * FRAME);
      check("short_relock",      int'(locked), 1);
      check("short_relock_edge", lock_fs - err_fs, 3);

      // HSync stops toggling while locked: timeout when the line overruns.
      gen_cycles(2 * T_HT);
      e0 = err_total;
      hold_h = 1'b1;
      gen_cycles(5);
      check("hsync_err",    err_total - e0, 1);
      check("hsync_err_at", err_cyc - hstart_cyc, 2);
      check("hsync_unlock", int'(locked), 0);
      gen_cycles(40);
      check("hsync_quiet",  err_total - e0, 1);
      hold_h = 1'b0;
      gen_to_frame_start();
      gen_cycles(3 * FRAME);
      check("hsync_relock", int'(locked), 1);

      // Reset pulse mid-frame while pixels are streaming.
      gen_cycles(5 * T_HT + 8);
      check("pre_reset_valid", int'(pix_bus.pix_valid), 1);
      reset = 1'b0;
      gen_cycles(1);
      check_all_zero("midreset");
      reset = 1'b1;
      fsr = fs_count;
      gen_to_frame_start();
      gen_cycles(3 * FRAME);
      check("reset_relock",      int'(locked), 1);
      check("reset_relock_edge", lock_fs - fsr, 3);

      gen_cycles(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
